pll_reset_sequencer: RTL and testbench

- Supervises the iCE40 PLL wrapper from the reference clock domain. Holds the PLL in reset, waits for a stable lock and then releases the downstream system reset.
- Monitors lock continuously. On lock loss it re-asserts system reset and restarts the PLL. Abandons the attempt and flags failure after a bounded number of retries.
- Sits between board clock/reset input and the pll instance. All core logic resets from its sys_reset.

---
 rtl/pll_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the iCE40 PLL. Holds the PLL in reset, waits for a
// synchronised, stable lock, then releases the downstream system reset.
module pll_reset_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_reset_n,
    output logic             sys_reset,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] unlock_count
);

    localparam int unsigned TMR_MAX_A = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
    localparam int unsigned TMR_MAX   = (LOCK_TIMEOUT > TMR_MAX_A) ? LOCK_TIMEOUT : TMR_MAX_A;
    localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] HOLD_END    = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_END    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_END  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       ATTEMPT_MAX = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    state_t             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [7:0]         attempts_q;
    logic               lk_meta_q;
    logic               lk_q;
    logic               pll_reset_n_q;
    logic               sys_reset_q;
    logic               ready_q;
    logic               fail_q;
    logic [CNT_W-1:0]   retry_count_q;
    logic [CNT_W-1:0]   unlock_count_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_q      <= lk_meta_q;
        end
    end

    // Sequencer FSM with registered outputs; the timer restarts on every state entry.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q        <= ST_HOLD;
            timer_q        <= '0;
            attempts_q     <= 8'd0;
            pll_reset_n_q  <= 1'b0;
            sys_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
            fail_q         <= 1'b0;
            retry_count_q  <= '0;
            unlock_count_q <= '0;
        end else if (relock_req) begin
            state_q       <= ST_HOLD;
            timer_q       <= '0;
            pll_reset_n_q <= 1'b0;
            sys_reset_q   <= 1'b1;
            ready_q       <= 1'b0;
            if (state_q == ST_FAIL) begin
                fail_q     <= 1'b0;
                attempts_q <= 8'd0;
            end
            // A lock loss coinciding with the request is still recorded.
            if (state_q == ST_RUN && !lk_q) begin
                unlock_count_q <= sat_inc(unlock_count_q);
            end
        end else begin
            timer_q <= timer_q + TMR_W'(1);
            case (state_q)
                ST_HOLD: begin
                    if (timer_q == HOLD_END) begin
                        state_q       <= ST_WAIT;
                        timer_q       <= '0;
                        pll_reset_n_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lk_q) begin
                        state_q <= ST_STABLE;
                        timer_q <= '0;
                    end else if (timer_q == WAIT_END) begin
                        timer_q       <= '0;
                        pll_reset_n_q <= 1'b0;
                        retry_count_q <= sat_inc(retry_count_q);
                        attempts_q    <= attempts_q + 8'd1;
                        if (attempts_q + 8'd1 == ATTEMPT_MAX) begin
                            state_q <= ST_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lk_q) begin
                        state_q <= ST_WAIT;
                        timer_q <= '0;
                    end else if (timer_q == STABLE_END) begin
                        state_q     <= ST_RUN;
                        timer_q     <= '0;
                        sys_reset_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    timer_q <= '0;
                    if (!lk_q) begin
                        state_q        <= ST_HOLD;
                        pll_reset_n_q  <= 1'b0;
                        sys_reset_q    <= 1'b1;
                        ready_q        <= 1'b0;
                        unlock_count_q <= sat_inc(unlock_count_q);
                    end
                end
                ST_FAIL: begin
                    timer_q <= '0;
                end
                default: begin
                    state_q       <= ST_HOLD;
                    timer_q       <= '0;
                    pll_reset_n_q <= 1'b0;
                    sys_reset_q   <= 1'b1;
                    ready_q       <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset_n  = pll_reset_n_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign fail         = fail_q;
    assign retry_count  = retry_count_q;
    assign unlock_count = unlock_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued when
// stimulus is applied and popped when the awaited output event occurs.
module tb_pll_reset_sequencer;

    logic       clock_in;
    logic       reset;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_reset_n;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [7:0] retry_count;
    logic [7:0] unlock_count;

    logic [3:0]  outs_s;
    logic [15:0] cnts_s;

    typedef struct {
        int         lat;
        logic [3:0] outs;
        logic [7:0] rc;
        logic [7:0] uc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total;
    int   n_bad;

    pll_reset_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (16),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3),
        .CNT_W        (8)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_reset_n (pll_reset_n),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .unlock_count(unlock_count)
    );

    assign outs_s = {pll_reset_n, sys_reset, ready, fail};
    assign cnts_s = {retry_count, unlock_count};

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic tick(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    function automatic logic hit(input int sel, input int val);
        case (sel)
            0:       return pll_reset_n == val[0];
            1:       return sys_reset == val[0];
            3:       return fail == val[0];
            4:       return int'(retry_count) == val;
            default: return 1'b0;
        endcase
    endfunction

    // Counts falling edges until the selected output reaches val; -1 if the budget expires.
    task automatic wait_for(input int sel, input int val, input int budget, output int n);
        n = 0;
        while (!hit(sel, val) && n < budget) begin
            @(negedge clock_in);
            n++;
        end
        if (!hit(sel, val)) n = -1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset      = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(3);
        exp_q.push_back('{0, 4'b0100, 8'd0, 8'd0});
        e = exp_q.pop_front();
        n_total++;
        if (outs_s !== e.outs) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want %b", outs_s, e.outs);
        end
        n_total++;
        if (cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL reset_counts: got %h want %h", cnts_s, {e.rc, e.uc});
        end
    endtask

    task automatic test_clean_lock();
        exp_t e;
        int   n;
        reset = 1'b0;
        exp_q.push_back('{4, 4'b1100, 8'd0, 8'd0});
        wait_for(0, 1, 50, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat) begin
            n_bad++;
            $display("FAIL clean_hold_len: got %0d want %0d", n, e.lat);
        end
        n_total++;
        if (outs_s !== e.outs) begin
            n_bad++;
            $display("FAIL clean_wait_outs: got %b want %b", outs_s, e.outs);
        end
        tick(6);
        pll_locked = 1'b1;
        exp_q.push_back('{11, 4'b1010, 8'd0, 8'd0});
        wait_for(1, 0, 50, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat) begin
            n_bad++;
            $display("FAIL clean_release_lat: got %0d want %0d", n, e.lat);
        end
        n_total++;
        if (outs_s !== e.outs) begin
            n_bad++;
            $display("FAIL clean_run_outs: got %b want %b", outs_s, e.outs);
        end
        n_total++;
        if (cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL clean_counts: got %h want %h", cnts_s, {e.rc, e.uc});
        end
    endtask

    task automatic test_run_loss();
        exp_t e;
        int   n;
        tick(3);
        pll_locked = 1'b0;
        exp_q.push_back('{3, 4'b0100, 8'd0, 8'd1});
        wait_for(1, 1, 20, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat) begin
            n_bad++;
            $display("FAIL loss_lat: got %0d want %0d", n, e.lat);
        end
        n_total++;
        if (outs_s !== e.outs) begin
            n_bad++;
            $display("FAIL loss_outs: got %b want %b", outs_s, e.outs);
        end
        n_total++;
        if (cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL loss_counts: got %h want %h", cnts_s, {e.rc, e.uc});
        end
        pll_locked = 1'b1;
        exp_q.push_back('{13, 4'b1010, 8'd0, 8'd1});
        wait_for(1, 0, 60, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat) begin
            n_bad++;
            $display("FAIL loss_relock_lat: got %0d want %0d", n, e.lat);
        end
        n_total++;
        if (outs_s !== e.outs) begin
            n_bad++;
            $display("FAIL loss_relock_outs: got %b want %b", outs_s, e.outs);
        end
        n_total++;
        if (cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL loss_relock_counts: got %h want %h", cnts_s, {e.rc, e.uc});
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   n;
        reset      = 1'b1;
        pll_locked = 1'b0;
        tick(2);
        reset = 1'b0;
        wait_for(0, 1, 20, n);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        exp_q.push_back('{0, 4'b1100, 8'd0, 8'd0});
        exp_q.push_back('{9, 4'b1010, 8'd0, 8'd0});
        tick(2);
        e = exp_q.pop_front();
        n_total++;
        if (outs_s !== e.outs) begin
            n_bad++;
            $display("FAIL glitch_wait_outs: got %b want %b", outs_s, e.outs);
        end
        wait_for(1, 0, 40, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat) begin
            n_bad++;
            $display("FAIL glitch_release_lat: got %0d want %0d", n, e.lat);
        end
        n_total++;
        if (cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL glitch_counts: got %h want %h", cnts_s, {e.rc, e.uc});
        end
    endtask

    task automatic test_never_lock();
        exp_t e;
        int   n;
        reset      = 1'b1;
        pll_locked = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back('{4, 4'b1100, 8'(k - 1), 8'd0});
            wait_for(0, 1, 50, n);
            e = exp_q.pop_front();
            n_total++;
            if (n !== e.lat || outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
                n_bad++;
                $display("FAIL never_hold_%0d: got lat=%0d outs=%b cnt=%h want lat=%0d outs=%b cnt=%h",
                         k, n, outs_s, cnts_s, e.lat, e.outs, {e.rc, e.uc});
            end
            exp_q.push_back('{16, (k == 3) ? 4'b0101 : 4'b0100, 8'(k), 8'd0});
            wait_for(4, k, 50, n);
            e = exp_q.pop_front();
            n_total++;
            if (n !== e.lat || outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
                n_bad++;
                $display("FAIL never_timeout_%0d: got lat=%0d outs=%b cnt=%h want lat=%0d outs=%b cnt=%h",
                         k, n, outs_s, cnts_s, e.lat, e.outs, {e.rc, e.uc});
            end
        end
        tick(200);
        exp_q.push_back('{0, 4'b0101, 8'd3, 8'd0});
        e = exp_q.pop_front();
        n_total++;
        if (outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL never_stays_failed: got outs=%b cnt=%h want outs=%b cnt=%h",
                     outs_s, cnts_s, e.outs, {e.rc, e.uc});
        end
    endtask

    task automatic test_relock_fail();
        exp_t e;
        int   n;
        relock_req = 1'b1;
        pll_locked = 1'b1;
        tick(1);
        relock_req = 1'b0;
        exp_q.push_back('{0, 4'b0100, 8'd3, 8'd0});
        e = exp_q.pop_front();
        n_total++;
        if (outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL relock_clear: got outs=%b cnt=%h want outs=%b cnt=%h",
                     outs_s, cnts_s, e.outs, {e.rc, e.uc});
        end
        exp_q.push_back('{13, 4'b1010, 8'd3, 8'd0});
        wait_for(1, 0, 60, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat || outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL relock_run: got lat=%0d outs=%b cnt=%h want lat=%0d outs=%b cnt=%h",
                     n, outs_s, cnts_s, e.lat, e.outs, {e.rc, e.uc});
        end
        // Fresh retry budget: three more timeouts must be needed to fail again.
        pll_locked = 1'b0;
        exp_q.push_back('{63, 4'b0101, 8'd6, 8'd1});
        wait_for(3, 1, 200, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat || outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL relock_refail: got lat=%0d outs=%b cnt=%h want lat=%0d outs=%b cnt=%h",
                     n, outs_s, cnts_s, e.lat, e.outs, {e.rc, e.uc});
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   n;
        relock_req = 1'b1;
        pll_locked = 1'b1;
        tick(1);
        relock_req = 1'b0;
        tick(8);
        exp_q.push_back('{0, 4'b1100, 8'd6, 8'd1});
        e = exp_q.pop_front();
        n_total++;
        if (outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL async_stable: got outs=%b cnt=%h want outs=%b cnt=%h",
                     outs_s, cnts_s, e.outs, {e.rc, e.uc});
        end
        #2;
        reset = 1'b1;
        exp_q.push_back('{0, 4'b0100, 8'd0, 8'd0});
        #1;
        e = exp_q.pop_front();
        n_total++;
        if (outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL async_immediate: got outs=%b cnt=%h want outs=%b cnt=%h",
                     outs_s, cnts_s, e.outs, {e.rc, e.uc});
        end
        tick(2);
        reset = 1'b0;
        exp_q.push_back('{4, 4'b1100, 8'd0, 8'd0});
        wait_for(0, 1, 20, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat || outs_s !== e.outs) begin
            n_bad++;
            $display("FAIL async_restart_hold: got lat=%0d outs=%b want lat=%0d outs=%b",
                     n, outs_s, e.lat, e.outs);
        end
        exp_q.push_back('{9, 4'b1010, 8'd0, 8'd0});
        wait_for(1, 0, 40, n);
        e = exp_q.pop_front();
        n_total++;
        if (n !== e.lat || outs_s !== e.outs || cnts_s !== {e.rc, e.uc}) begin
            n_bad++;
            $display("FAIL async_restart_run: got lat=%0d outs=%b cnt=%h want lat=%0d outs=%b cnt=%h",
                     n, outs_s, cnts_s, e.lat, e.outs, {e.rc, e.uc});
        end
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_clean_lock();
        test_run_loss();
        test_glitch();
        test_never_lock();
        test_relock_fail();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
